// File: rtl/fir_ntap_mac.sv
// fir_ntap_mac -- N-tap signed FIR filter built around one time-multiplexed MAC.
//
// Each accepted sample is shifted into the delay line, then TAPS cycles of
// multiply-accumulate compute y = sum h[k]*d[k] (d[0] = newest sample). The
// result is published for one cycle in OUT. Coefficients are loadable only
// while idle and persist across sessions. Q8.8 samples and coefficients give
// a Q16.16 result.
//
// Optional feature macro: FIR_SAT_EN
//   defined   : y is the accumulator clamped to the signed 2*DATAWIDTH range
//   undefined : y is the low 2*DATAWIDTH bits of the accumulator (wraps)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   start      open a session (IDLE only)
//   stop       close the session (immediately in WAIT, after OUT otherwise)
//   coef_we    coefficient write strobe (IDLE only)
//   coef_addr  coefficient index; indices >= TAPS are ignored
//   coef_data  coefficient value
//   x/x_valid  sample and its valid
//   x_ready    block accepts a sample this cycle (WAIT)
//   y          filter output, held until the next result
//   y_valid    one-cycle pulse when y updates
//   busy       session active
//   done       one-cycle pulse when a session ends
module fir_ntap_mac #(
  parameter  int DATAWIDTH = 16,
  parameter  int TAPS      = 3,
  localparam int ADDRW     = $clog2(TAPS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   coef_we,
  input  logic [ADDRW-1:0]       coef_addr,
  input  logic [DATAWIDTH-1:0]   coef_data,
  input  logic [DATAWIDTH-1:0]   x,
  input  logic                   x_valid,
  output logic                   x_ready,
  output logic [2*DATAWIDTH-1:0] y,
  output logic                   y_valid,
  output logic                   busy,
  output logic                   done
);

  localparam int PW   = 2 * DATAWIDTH;
  localparam int ACCW = PW + ADDRW;
  localparam logic [ADDRW-1:0] LAST = ADDRW'(TAPS - 1);

  typedef enum logic [1:0] {IDLE, WAIT, MAC, OUT} state_t;

  state_t state, state_nxt;

  // Coefficients and delay line as packed arrays; element 0 of d is newest.
  logic [TAPS-1:0][DATAWIDTH-1:0] h;
  logic [TAPS-1:0][DATAWIDTH-1:0] d;

  logic signed [ACCW-1:0] acc;
  logic [ADDRW-1:0]       k;
  logic                   stop_pend;
  logic                   done_set;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    x_ready   = 1'b0;
    busy      = (state != IDLE);
    done_set  = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = WAIT;
      WAIT: begin
        x_ready = 1'b1;
        // A handshake takes priority over stop; a simultaneous stop is
        // remembered in stop_pend and honoured after OUT.
        if (x_valid) begin
          state_nxt = MAC;
        end else if (stop) begin
          state_nxt = IDLE;
          done_set  = 1'b1;
        end
      end
      MAC:  if (k == LAST) state_nxt = OUT;
      OUT: begin
        state_nxt = stop_pend ? IDLE : WAIT;
        done_set  = stop_pend;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // MAC datapath
  // ---------------------------------------------------------------------------
  // Operands are sign-extended to the product width so the multiply is
  // width-matched; the low PW bits of that product are the exact signed result.
  logic signed [PW-1:0]   h_ext, d_ext, prod;
  logic signed [ACCW-1:0] prod_ext;

  assign h_ext    = {{DATAWIDTH{h[k][DATAWIDTH-1]}}, h[k]};
  assign d_ext    = {{DATAWIDTH{d[k][DATAWIDTH-1]}}, d[k]};
  assign prod     = h_ext * d_ext;
  assign prod_ext = {{ADDRW{prod[PW-1]}}, prod};

  // The ADDRW guard bits make the accumulator wide enough for TAPS
  // full-scale products, so only the final narrowing can overflow.
  logic [PW-1:0] y_nxt;

`ifdef FIR_SAT_EN
  localparam logic signed [ACCW-1:0] YMAX = {{(ADDRW+1){1'b0}}, {(PW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] YMIN = {{(ADDRW+1){1'b1}}, {(PW-1){1'b0}}};

  always_comb begin
    y_nxt = acc[PW-1:0];
    if (acc > YMAX)      y_nxt = YMAX[PW-1:0];
    else if (acc < YMIN) y_nxt = YMIN[PW-1:0];
  end
`else
  assign y_nxt = acc[PW-1:0];
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h         <= '0;
      d         <= '0;
      acc       <= '0;
      k         <= '0;
      stop_pend <= 1'b0;
      y         <= '0;
      y_valid   <= 1'b0;
      done      <= 1'b0;
    end else begin
      y_valid <= 1'b0;
      done    <= done_set;
      case (state)
        IDLE: begin
          if (coef_we && coef_addr <= LAST) h[coef_addr] <= coef_data;
          // A new session never sees taps left over from the previous one.
          if (start) begin
            d         <= '0;
            stop_pend <= 1'b0;
          end
        end
        WAIT: begin
          if (x_valid) begin
            d         <= {d[TAPS-2:0], x};
            acc       <= '0;
            k         <= '0;
            stop_pend <= stop;
          end
        end
        MAC: begin
          acc <= acc + prod_ext;
          k   <= k + 1'b1;
          if (stop) stop_pend <= 1'b1;
        end
        OUT: begin
          y         <= y_nxt;
          y_valid   <= 1'b1;
          stop_pend <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
